bram_port_adapter: RTL and testbench

Valid/ready front-end for a single-port byte-enabled block RAM: it accepts read and write requests from a core-side client and drives the RAM's address, data, write-enable, read-enable and byte-enable pins. It captures the RAM's one-cycle-late read data into a small response FIFO and applies credit-based backpressure, so no read result is ever dropped. It sits directly upstream of the byte-enabled block RAM, between it and a cache or DMA client.

---
 rtl/mem_pkg.sv | 16 +
 rtl/bram_rsp_fifo.sv | 38 +++
 rtl/bram_port_adapter.sv | 59 +++++
 tb/tb_bram_port_adapter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared request/response types and sizing constants for the BRAM port adapter
package mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W = DATA_W / 8;
  localparam int RSP_DEPTH_MIN = 2;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   mask;
  } mem_req_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } mem_rsp_t;
endpackage

// File: rtl/bram_rsp_fifo.sv
// bram_rsp_fifo: first-word-fall-through response FIFO with a separate count so full and empty differ
module bram_rsp_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 3,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          valid
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign valid = count != '0;
  assign dout = mem[rd_ptr];
  assign do_pop = pop && valid;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
endmodule

// File: rtl/bram_port_adapter.sv
// bram_port_adapter: valid/ready front-end for a byte-enabled single-port BRAM with
// credit-based read backpressure so every read result fits in the response FIFO.
module bram_port_adapter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter int RSP_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [BE_WIDTH-1:0]   req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  output logic                  bram_we,
  output logic                  bram_re,
  output logic [BE_WIDTH-1:0]   bram_be,
  input  logic [DATA_WIDTH-1:0] bram_do
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  if (RSP_DEPTH < RSP_DEPTH_MIN || DATA_WIDTH % 8 != 0) begin : g_bad_cfg
    $error("bram_port_adapter: RSP_DEPTH must be >= 2 and DATA_WIDTH a multiple of 8");
  end
  logic inflight;
  logic [CW-1:0] count;
  logic [CW:0] credit;
  logic accept;
  // credit counts the read already on its way from the RAM, so a push never finds the FIFO full
  assign credit = {1'b0, count} + (CW + 1)'(inflight);
  assign req_ready = rst_n && (req_write || credit < (CW + 1)'(RSP_DEPTH));
  assign accept = req_valid && req_ready;
  assign bram_we = accept && req_write;
  assign bram_re = accept && !req_write;
  assign bram_addr = accept ? req_addr : '0;
  assign bram_di = bram_we ? req_data : '0;
  assign bram_be = bram_we ? req_mask : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) inflight <= 1'b0;
    else inflight <= bram_re;
  bram_rsp_fifo #(.W(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (rsp_valid && rsp_ready),
    .din   (bram_do),
    .dout  (rsp_data),
    .count (count),
    .valid (rsp_valid)
  );
endmodule

// File: tb/tb_bram_port_adapter.sv
// tb_bram_port_adapter: table-driven and directed checks of the BRAM adapter against a
// behavioural byte-enabled RAM and a scoreboard queue of expected read data.
module tb_bram_port_adapter;
  import mem_pkg::*;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  typedef struct {
    mem_req_t       req;
    logic [DW-1:0]  exp;
  } vec_t;
  logic clk = 0;
  logic rst_n = 0;
  logic req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, bram_addr;
  logic [DW-1:0] req_data, rsp_data, bram_di, bram_do;
  logic [BW-1:0] req_mask, bram_be;
  logic bram_we, bram_re;
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] model_mem [1<<AW];
  logic [DW-1:0] q [$];
  int n_cmp = 0;
  int n_fail = 0;
  vec_t tbl [8];

  always #5 clk = ~clk;

  bram_port_adapter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_mask  (req_mask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .bram_addr (bram_addr),
    .bram_di   (bram_di),
    .bram_we   (bram_we),
    .bram_re   (bram_re),
    .bram_be   (bram_be),
    .bram_do   (bram_do)
  );

  // behavioural byte-enabled RAM with one-cycle read latency
  always @(posedge clk) begin
    if (bram_we)
      for (int b = 0; b < BW; b++)
        if (bram_be[b]) ram[bram_addr][8*b +: 8] <= bram_di[8*b +: 8];
    if (bram_re) bram_do <= ram[bram_addr];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      check("we_re_exclusive", DW'(bram_we & bram_re), 0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_rsp: got %h expected no response", rsp_data);
        end else check("rsp_data", rsp_data, q.pop_front());
      end
    end

  function automatic vec_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [BW-1:0] m, input logic [DW-1:0] e);
    vec_t v;
    v.req.write = wr;
    v.req.addr = a;
    v.req.data = d;
    v.req.mask = m;
    v.exp = e;
    return v;
  endfunction

  task automatic send(input mem_req_t r, input logic [DW-1:0] exp, input bit use_exp, output int waits);
    waits = 0;
    req_valid = 1;
    req_write = r.write;
    req_addr = r.addr;
    req_data = r.data;
    req_mask = r.mask;
    @(negedge clk);
    while (!req_ready && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    check("req_accept", DW'(req_ready), 1);
    if (req_ready) begin
      check("bram_we", DW'(bram_we), DW'(r.write));
      check("bram_re", DW'(bram_re), DW'(!r.write));
      check("bram_addr", DW'(bram_addr), DW'(r.addr));
      check("bram_be", DW'(bram_be), r.write ? DW'(r.mask) : 0);
      if (r.write) begin
        check("bram_di", bram_di, r.data);
        for (int b = 0; b < BW; b++)
          if (r.mask[b]) model_mem[r.addr][8*b +: 8] = r.data[8*b +: 8];
      end else q.push_back(use_exp ? exp : model_mem[r.addr]);
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] m, output int waits);
    vec_t v = mk(1, a, d, m, 0);
    send(v.req, 0, 0, waits);
  endtask

  task automatic rd(input logic [AW-1:0] a, output int waits);
    vec_t v = mk(0, a, 0, 0, 0);
    send(v.req, 0, 0, waits);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (q.size() != 0 && t < 64) begin
      @(negedge clk);
      t++;
    end
    check(name, DW'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, total;
    tbl[0] = mk(1, 7, 32'h1122_3344, 4'hF, 0);
    tbl[1] = mk(1, 7, 32'hAA55_AA55, 4'b0101, 0);
    tbl[2] = mk(0, 7, 0, 0, 32'h1155_3355);
    tbl[3] = mk(1, 9, 32'hCAFE_F00D, 4'hF, 0);
    tbl[4] = mk(0, 9, 0, 0, 32'hCAFE_F00D);
    tbl[5] = mk(1, 12, 32'h1234_5678, 4'hF, 0);
    tbl[6] = mk(1, 12, 32'hFFFF_FFFF, 4'h0, 0);
    tbl[7] = mk(0, 12, 0, 0, 32'h1234_5678);
    req_valid = 1;
    req_write = 1;
    req_addr = 0;
    req_data = 0;
    req_mask = 4'hF;
    rsp_ready = 1;
    #12;
    check("rst_req_ready", DW'(req_ready), 0);
    check("rst_bram_we", DW'(bram_we), 0);
    check("rst_bram_re", DW'(bram_re), 0);
    check("rst_rsp_valid", DW'(rsp_valid), 0);
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    wr(5, 32'hDEAD_BEEF, 4'hF, w);
    rd(5, w);
    @(negedge clk);
    check("lat_n1_valid", DW'(rsp_valid), 0);
    @(negedge clk);
    check("lat_n2_valid", DW'(rsp_valid), 1);
    check("lat_n2_data", rsp_data, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    drain("lat_drain");
    for (int i = 0; i < 8; i++) send(tbl[i].req, tbl[i].exp, 1, w);
    drain("tbl_drain");
    for (int i = 0; i < 16; i++) wr(AW'(i), {4{8'(i)}} ^ 32'h5A5A_0000, 4'hF, w);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      rd(AW'(i), w);
      total += w;
    end
    check("b2b_stalls", DW'(total), 0);
    drain("b2b_drain");
    rsp_ready = 0;
    total = 0;
    for (int i = 1; i <= 3; i++) begin
      rd(AW'(i), w);
      total += w;
    end
    check("bp_first3_stalls", DW'(total), 0);
    req_valid = 1;
    req_write = 0;
    req_addr = 4;
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", DW'(req_ready), 0);
    end
    check("bp_rsp_valid", DW'(rsp_valid), 1);
    @(posedge clk);
    #1;
    req_valid = 0;
    wr(20, 32'h0BAD_CAFE, 4'hF, w);
    check("bp_write_stalls", DW'(w), 0);
    rsp_ready = 1;
    rd(4, w);
    check("bp_read_waited", DW'(w != 0), 1);
    drain("bp_drain");
    rsp_ready = 0;
    for (int i = 1; i <= 3; i++) rd(AW'(i), w);
    #2;
    rst_n = 0;
    req_valid = 1;
    req_write = 0;
    req_addr = 2;
    #1;
    check("midrst_rsp_valid", DW'(rsp_valid), 0);
    check("midrst_req_ready", DW'(req_ready), 0);
    check("midrst_bram_re", DW'(bram_re), 0);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #2;
    req_valid = 0;
    rst_n = 1;
    rsp_ready = 1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", DW'(rsp_valid), 0);
    end
    @(posedge clk);
    #1;
    rd(9, w);
    drain("post_rst_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
